// File: rtl/raycast_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : raycast_scheduler
// Purpose  : Per-frame sequencer for the raycaster. On each accepted frame
//            start it latches the player pose, then for every screen column
//            issues one ray request, waits for the result (bounded by a
//            timeout) and writes {side, height} into the column line buffer.
// Options  : RAYCAST_DOUBLE_BUFFER_EN adds buf_bank / disp_bank bank
//            selects. The bank toggles only on a completed frame.
// Revision : 1.0 - initial release
// ============================================================================
module raycast_scheduler #(
    parameter int NUM_COLS = 160,
    parameter int COL_W    = 8,
    parameter int HEIGHT_W = 8,
    parameter int POS_W    = 16,
    parameter int ANG_W    = 8,
    parameter int TIMEOUT  = 1023
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                frame_start,
    input  logic                enable,
    input  logic [POS_W-1:0]    pos_x_in,
    input  logic [POS_W-1:0]    pos_y_in,
    input  logic [ANG_W-1:0]    angle_in,
    output logic                ray_start,
    output logic [COL_W-1:0]    ray_col,
    output logic [POS_W-1:0]    ray_pos_x,
    output logic [POS_W-1:0]    ray_pos_y,
    output logic [ANG_W-1:0]    ray_angle,
    input  logic                ray_done,
    input  logic [HEIGHT_W-1:0] ray_height,
    input  logic                ray_side,
    output logic                buf_we,
    output logic [COL_W-1:0]    buf_addr,
    output logic [HEIGHT_W:0]   buf_wdata,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun,
    output logic                timeout_err
`ifdef RAYCAST_DOUBLE_BUFFER_EN
    ,
    output logic                buf_bank,
    output logic                disp_bank
`endif
);

    // Timeout counter only needs to reach TIMEOUT.
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_q,       state_d;
    logic [COL_W-1:0]    col_q,         col_d;
    logic [TMO_W-1:0]    tmo_cnt_q,     tmo_cnt_d;
    logic [POS_W-1:0]    pos_x_q,       pos_x_d;
    logic [POS_W-1:0]    pos_y_q,       pos_y_d;
    logic [ANG_W-1:0]    angle_q,       angle_d;
    logic                ray_start_q,   ray_start_d;
    logic [COL_W-1:0]    ray_col_q,     ray_col_d;
    logic                buf_we_q,      buf_we_d;
    logic [COL_W-1:0]    buf_addr_q,    buf_addr_d;
    logic [HEIGHT_W:0]   buf_wdata_q,   buf_wdata_d;
    logic                busy_q,        busy_d;
    logic                frame_done_q,  frame_done_d;
    logic                overrun_q,     overrun_d;
    logic                timeout_err_q, timeout_err_d;
`ifdef RAYCAST_DOUBLE_BUFFER_EN
    logic                buf_bank_q,    buf_bank_d;
`endif

    // Next-state and next-output logic; pulses are prepared one cycle ahead
    // so that every output comes straight from a flop.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        tmo_cnt_d     = tmo_cnt_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        angle_d       = angle_q;
        ray_start_d   = 1'b0;
        ray_col_d     = ray_col_q;
        buf_we_d      = 1'b0;
        buf_addr_d    = buf_addr_q;
        buf_wdata_d   = buf_wdata_q;
        frame_done_d  = 1'b0;
        overrun_d     = overrun_q | (frame_start & (state_q != S_IDLE));
        timeout_err_d = timeout_err_q;
`ifdef RAYCAST_DOUBLE_BUFFER_EN
        buf_bank_d    = buf_bank_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (frame_start && enable) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                // Pose is frozen here for the whole frame.
                pos_x_d     = pos_x_in;
                pos_y_d     = pos_y_in;
                angle_d     = angle_in;
                col_d       = '0;
                ray_start_d = 1'b1;
                ray_col_d   = '0;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (ray_done) begin
                    // A result on the expiry cycle still counts as a result.
                    buf_we_d    = 1'b1;
                    buf_addr_d  = col_q;
                    buf_wdata_d = {ray_side, ray_height};
                    state_d     = S_WRITE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                    if (tmo_cnt_q == TMO_LAST) begin
                        buf_we_d      = 1'b1;
                        buf_addr_d    = col_q;
                        buf_wdata_d   = '0;
                        timeout_err_d = 1'b1;
                        state_d       = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (col_q == LAST_COL) begin
                    frame_done_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    col_d       = col_q + COL_ONE;
                    ray_start_d = 1'b1;
                    ray_col_d   = col_q + COL_ONE;
                    state_d     = S_ISSUE;
                end
            end
            S_DONE: begin
`ifdef RAYCAST_DOUBLE_BUFFER_EN
                // Only a complete frame swaps the banks.
                buf_bank_d = ~buf_bank_q;
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            tmo_cnt_q     <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            angle_q       <= '0;
            ray_start_q   <= 1'b0;
            ray_col_q     <= '0;
            buf_we_q      <= 1'b0;
            buf_addr_q    <= '0;
            buf_wdata_q   <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef RAYCAST_DOUBLE_BUFFER_EN
            buf_bank_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            tmo_cnt_q     <= tmo_cnt_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            angle_q       <= angle_d;
            ray_start_q   <= ray_start_d;
            ray_col_q     <= ray_col_d;
            buf_we_q      <= buf_we_d;
            buf_addr_q    <= buf_addr_d;
            buf_wdata_q   <= buf_wdata_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
`ifdef RAYCAST_DOUBLE_BUFFER_EN
            buf_bank_q    <= buf_bank_d;
`endif
        end
    end

    assign ray_start   = ray_start_q;
    assign ray_col     = ray_col_q;
    assign ray_pos_x   = pos_x_q;
    assign ray_pos_y   = pos_y_q;
    assign ray_angle   = angle_q;
    assign buf_we      = buf_we_q;
    assign buf_addr    = buf_addr_q;
    assign buf_wdata   = buf_wdata_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;
`ifdef RAYCAST_DOUBLE_BUFFER_EN
    assign buf_bank    = buf_bank_q;
    assign disp_bank   = ~buf_bank_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_raycast_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_raycast_scheduler
// Purpose  : Self-checking bench for raycast_scheduler (4 columns, timeout 8)
//            with a raycaster responder and a timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raycast_scheduler;

    localparam int NC  = 4;
    localparam int CW  = 8;
    localparam int HW  = 8;
    localparam int PW  = 16;
    localparam int AW  = 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          RST;
    logic          frame_start, enable;
    logic [PW-1:0] pos_x_in, pos_y_in;
    logic [AW-1:0] angle_in;
    logic          ray_start;
    logic [CW-1:0] ray_col;
    logic [PW-1:0] ray_pos_x, ray_pos_y;
    logic [AW-1:0] ray_angle;
    logic          ray_done;
    logic [HW-1:0] ray_height;
    logic          ray_side;
    logic          buf_we;
    logic [CW-1:0] buf_addr;
    logic [HW:0]   buf_wdata;
    logic          busy, frame_done, overrun, timeout_err;
`ifdef RAYCAST_DOUBLE_BUFFER_EN
    logic          buf_bank, disp_bank;
`endif

    raycast_scheduler #(
        .NUM_COLS(NC), .COL_W(CW), .HEIGHT_W(HW), .POS_W(PW), .ANG_W(AW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .RST(RST), .frame_start(frame_start), .enable(enable),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .angle_in(angle_in),
        .ray_start(ray_start), .ray_col(ray_col), .ray_pos_x(ray_pos_x),
        .ray_pos_y(ray_pos_y), .ray_angle(ray_angle), .ray_done(ray_done),
        .ray_height(ray_height), .ray_side(ray_side), .buf_we(buf_we),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
`ifdef RAYCAST_DOUBLE_BUFFER_EN
        , .buf_bank(buf_bank), .disp_bank(disp_bank)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- raycaster responder ----------------
    int            rsp_k [NC];   // 0 = never answer
    logic [HW-1:0] rsp_h [NC];
    logic          rsp_s [NC];
    int            r_pend = 0, r_at = 0, r_col = 0;
    bit            noise_en = 0;

    initial begin
        ray_done = 0; ray_height = 0; ray_side = 0;
        forever begin
            @(posedge clk); #1;
            if (!RST) r_pend = 0;
            ray_done   = 1'b0;
            ray_height = HW'($urandom);
            ray_side   = 1'($urandom);
            if (r_pend != 0 && cyc == r_at) begin
                ray_done   = 1'b1;
                ray_height = rsp_h[r_col];
                ray_side   = rsp_s[r_col];
                r_pend     = 0;
            end else if (noise_en && $urandom_range(0, 19) == 0) begin
                ray_done = 1'b1;
            end
            if (RST && ray_start && int'(ray_col) < NC) begin
                r_col = int'(ray_col);
                if (rsp_k[r_col] != 0) begin
                    r_pend = 1;
                    r_at   = cyc + rsp_k[r_col];
                end
            end
        end
    end

    // ---------------- pose driver ----------------
    bit            pose_rand = 0;
    logic [PW-1:0] px_hist [int];
    initial forever begin
        @(posedge clk); #1;
        if (pose_rand) begin
            pos_x_in = PW'($urandom);
            pos_y_in = PW'($urandom);
            angle_in = AW'($urandom);
            px_hist[cyc] = pos_x_in;
        end
    end

    // ---------------- timeline reference model ----------------
    bit            m_active, m_waiting, m_overrun, m_tmo, m_bank;
    int            m_col, m_latch_at, m_start_at, m_write_at, m_done_at;
    logic [HW:0]   m_wdata;
    logic [PW-1:0] m_px, m_py;
    logic [AW-1:0] m_ang;

    typedef struct packed {
        logic [31:0] cyc;
        logic [CW-1:0] addr;
        logic [HW:0] data;
    } wr_t;
    wr_t wlog[$];
    int  slog[$];
    int  fdlog[$];
    int  fd_total = 0;

    task automatic model_reset();
        m_active = 0; m_waiting = 0; m_overrun = 0; m_tmo = 0; m_bank = 0;
        m_col = 0; m_latch_at = -1; m_start_at = -1; m_write_at = -1; m_done_at = -1;
        m_wdata = '0; m_px = '0; m_py = '0; m_ang = '0;
    endtask

    always @(negedge clk) begin
        bit was_active;
        wr_t w;
        if (!RST) begin
            model_reset();
        end else begin
            // compare this cycle's outputs with the model
            chk("busy", busy, m_active);
            chk("ray_start", ray_start, cyc == m_start_at);
            if (cyc == m_start_at) chk("ray_col", ray_col, m_col);
            chk("buf_we", buf_we, cyc == m_write_at);
            if (cyc == m_write_at) begin
                chk("buf_addr", buf_addr, m_col);
                chk("buf_wdata", buf_wdata, m_wdata);
            end
            chk("frame_done", frame_done, cyc == m_done_at);
            chk("overrun", overrun, m_overrun);
            chk("timeout_err", timeout_err, m_tmo);
            if (m_active && cyc > m_latch_at) begin
                chk("ray_pos_x", ray_pos_x, m_px);
                chk("ray_pos_y", ray_pos_y, m_py);
                chk("ray_angle", ray_angle, m_ang);
            end
`ifdef RAYCAST_DOUBLE_BUFFER_EN
            chk("buf_bank", buf_bank, m_bank);
            chk("disp_bank", disp_bank, !m_bank);
`endif
            // observed-event logs for the directed literal checks
            if (ray_start) slog.push_back(cyc);
            if (buf_we) begin
                w.cyc = cyc; w.addr = buf_addr; w.data = buf_wdata;
                wlog.push_back(w);
            end
            if (frame_done) begin
                fdlog.push_back(cyc);
                fd_total++;
            end
            // advance the model with this cycle's inputs
            was_active = m_active;
            if (frame_start && was_active) m_overrun = 1;
            if (!was_active && frame_start && enable) begin
                m_active = 1; m_col = 0; m_latch_at = cyc + 1; m_start_at = cyc + 2;
            end
            if (cyc == m_latch_at) begin
                m_px = pos_x_in; m_py = pos_y_in; m_ang = angle_in;
            end
            if (m_waiting) begin
                if (ray_done) begin
                    m_wdata = {ray_side, ray_height}; m_write_at = cyc + 1; m_waiting = 0;
                end else if (cyc == m_start_at + TMO) begin
                    m_wdata = '0; m_tmo = 1; m_write_at = cyc + 1; m_waiting = 0;
                end
            end
            if (cyc == m_start_at) m_waiting = 1;
            if (cyc == m_write_at) begin
                if (!enable) m_active = 0;
                else if (m_col == NC - 1) m_done_at = cyc + 1;
                else begin
                    m_col++; m_start_at = cyc + 1;
                end
            end
            if (cyc == m_done_at) begin
                m_active = 0; m_bank = !m_bank;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int F;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1; F = cyc;
        step();
        frame_start = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (m_active && n < 300) begin step(); n++; end
        if (m_active) begin
            n_tests++; n_fail++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic wait_starts(input int count, input string name);
        int n = 0;
        while (slog.size() < count && n < 300) begin step(); n++; end
        if (slog.size() < count) begin
            n_tests++; n_fail++;
            $display("FAIL %s: saw %0d ray_start, required %0d", name, slog.size(), count);
        end
    endtask

    task automatic clear_logs();
        wlog.delete(); slog.delete(); fdlog.delete();
    endtask

    task automatic set_basic_rsp(input int k1);
        for (int i = 0; i < NC; i++) begin
            rsp_k[i] = 3; rsp_h[i] = HW'(i * 10); rsp_s[i] = 1'(i);
        end
        rsp_k[1] = k1;
    endtask

    task automatic do_reset();
        step(); RST = 0; step(); step(); RST = 1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic bank0;
        RST = 0; frame_start = 0; enable = 0;
        pos_x_in = '0; pos_y_in = '0; angle_in = '0;
        set_basic_rsp(3);
        step(); step(); step();
        // reset state
        chk("rst busy", busy, 0);
        chk("rst ray_pos_x", ray_pos_x, 0);
        chk("rst buf_wdata", buf_wdata, 0);
        chk("rst overrun", overrun, 0);
        RST = 1;
        step();

        // basic frame
        enable = 1; pos_x_in = 16'h1234; pos_y_in = 16'h5678; angle_in = 8'h40;
        clear_logs(); pulse_fs(); wait_idle("basic");
        chk("basic writes", wlog.size(), 4);
        if (wlog.size() == 4) begin
            chk("basic d0", {wlog[0].addr, 7'd0, wlog[0].data}, {8'd0, 7'd0, 9'h000});
            chk("basic d1", {wlog[1].addr, 7'd0, wlog[1].data}, {8'd1, 7'd0, 9'h10A});
            chk("basic d2", {wlog[2].addr, 7'd0, wlog[2].data}, {8'd2, 7'd0, 9'h014});
            chk("basic d3", {wlog[3].addr, 7'd0, wlog[3].data}, {8'd3, 7'd0, 9'h11E});
        end
        chk("basic fd count", fdlog.size(), 1);
        if (fdlog.size() == 1) chk("basic fd latency", fdlog[0] - F, 22);
        chk("model fd latency", m_done_at - F, 22);
        chk("basic pose x", ray_pos_x, 16'h1234);
        chk("basic pose y", ray_pos_y, 16'h5678);
        chk("basic angle", ray_angle, 8'h40);
`ifdef RAYCAST_DOUBLE_BUFFER_EN
        chk("basic bank", buf_bank, 1);
`endif

        // pose stability
        pose_rand = 1; step(); step();
        clear_logs(); pulse_fs(); wait_idle("pose");
        chk("pose latched", ray_pos_x, px_hist[F + 1]);
        pose_rand = 0;

        // overrun
        clear_logs(); pulse_fs(); wait_starts(3, "overrun col2");
        pulse_fs(); wait_idle("overrun");
        chk("overrun set", overrun, 1);
        chk("overrun writes", wlog.size(), 4);
        chk("overrun fd", fdlog.size(), 1);

        // timeout on column 1
        do_reset(); set_basic_rsp(0);
        clear_logs(); pulse_fs(); wait_idle("timeout");
        chk("tmo writes", wlog.size(), 4);
        if (wlog.size() == 4 && slog.size() == 4) begin
            chk("tmo data", wlog[1].data, 0);
            chk("tmo latency", int'(wlog[1].cyc) - slog[1], TMO + 1);
            chk("tmo next col", wlog[2].data, 9'h014);
        end
        chk("tmo flag", timeout_err, 1);

        // result on the expiry cycle wins
        do_reset(); set_basic_rsp(TMO);
        clear_logs(); pulse_fs(); wait_idle("done wins");
        if (wlog.size() == 4 && slog.size() == 4) begin
            chk("win data", wlog[1].data, 9'h10A);
            chk("win latency", int'(wlog[1].cyc) - slog[1], TMO + 1);
        end
        chk("win flag", timeout_err, 0);

        // abort during WAIT of column 2
        set_basic_rsp(3);
`ifdef RAYCAST_DOUBLE_BUFFER_EN
        bank0 = buf_bank;
`else
        bank0 = 0;
`endif
        clear_logs(); pulse_fs(); wait_starts(3, "abort col2");
        enable = 0; wait_idle("abort");
        chk("abort writes", wlog.size(), 3);
        chk("abort no fd", fdlog.size(), 0);
`ifdef RAYCAST_DOUBLE_BUFFER_EN
        chk("abort bank", buf_bank, bank0);
`endif
        enable = 1;
        clear_logs(); pulse_fs(); wait_idle("after abort");
`ifdef RAYCAST_DOUBLE_BUFFER_EN
        chk("full bank", buf_bank, !bank0);
`endif

        // async reset mid-WAIT
        clear_logs(); pulse_fs(); wait_starts(2, "areset col1");
        #2; RST = 0; #1;
        chk("areset ray_start", ray_start, 0);
        chk("areset busy", busy, 0);
        chk("areset pose", {ray_pos_x, ray_angle}, 0);
        chk("areset buf", {buf_we, buf_addr, buf_wdata}, 0);
        chk("areset flags", {frame_done, overrun, timeout_err, ray_col}, 0);
        step(); step(); RST = 1;
        enable = 0;
        for (int i = 0; i < 4; i++) begin pulse_fs(); step(); end
        chk("gated busy", busy, 0);
        chk("gated overrun", overrun, 0);
        enable = 1;
        clear_logs(); pulse_fs(); wait_idle("post reset");
        chk("post reset writes", wlog.size(), 4);

        // randomized traffic against the model
        pose_rand = 1; noise_en = 1; fd_total = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!m_active) begin
                for (int c = 0; c < NC; c++) begin
                    rsp_k[c] = $urandom_range(0, 10);
                    rsp_h[c] = HW'($urandom);
                    rsp_s[c] = 1'($urandom);
                end
            end
            frame_start = ($urandom_range(0, 11) == 0);
            enable      = ($urandom_range(0, 29) != 0);
            step();
        end
        frame_start = 0; enable = 1; noise_en = 0;
        wait_idle("random drain");
        chk("random frames done", fd_total > 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
